print_event_arbiter: RTL and testbench
======================================

PRINT_EVENT_ARBITER -- requirements
Module: print_event_arbiter

Interface
REQ-001 SHALL have parameter TIMESTAMP_WIDTH, default 32: width of the free-running event timestamp.
REQ-002 SHALL have parameter DROP_WIDTH, default 16: width of the saturating drop counter.
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  1 = forward events, 0 = accept-and-discard.
REQ-006 SHALL have port head_valid  input  1  thermal-head line available.
REQ-007 SHALL have port head_ready  output  1  head line accepted this cycle when high with head_valid.
REQ-008 SHALL have port head_data  input  512  thermal-head active dots.
REQ-009 SHALL have port motor_valid  input  1  motor step event available.
REQ-010 SHALL have port motor_ready  output  1  motor event accepted this cycle when high with motor_valid.
REQ-011 SHALL have port motor_data  input  32  signed motor step count.
REQ-012 SHALL have port out_valid  output  1  out_* holds an event.
REQ-013 SHALL have port out_ready  input  1  downstream accepts event.
REQ-014 SHALL have port out_tag  output  2  01 = head line, 10 = motor event, 00 = none.
REQ-015 SHALL have port out_data  output  512  event payload.
REQ-016 SHALL have port out_timestamp  output  TIMESTAMP_WIDTH  cycle count at acceptance.
REQ-017 SHALL have port drop_count  output  DROP_WIDTH  events discarded while disabled.

Function
REQ-018 SHALL keep a free-running timestamp counter, +1 every clk, wrapping from all-ones to 0.
REQ-019 SHALL implement states IDLE and HOLD; out_valid = 1 exactly when in HOLD.
REQ-020 In IDLE with enable=1, SHALL drive ready high combinationally to exactly one requester: the only valid one, or if both valid the one not granted last; neither ready if no valid.
REQ-021 Last-grant SHALL be reset to motor, so head wins the first simultaneous contention.
REQ-022 On an accepted beat in IDLE (cycle N), SHALL register payload, tag and timestamp value of cycle N, update last-grant and enter HOLD; out_valid high from cycle N+1.
REQ-023 Head payload SHALL pass unchanged; motor payload SHALL be motor_data zero-extended in out_data[31:0], bits 511:32 zero.
REQ-024 In HOLD, head_ready and motor_ready SHALL be 0; out_* SHALL be stable until out_valid && out_ready.
REQ-025 On out_valid && out_ready, SHALL return to IDLE next cycle with out_valid=0, out_tag=00, out_data=0, out_timestamp=0; no new accept in that handshake cycle (max throughput one event per 2 cycles).
REQ-026 In IDLE with enable=0, SHALL drive head_ready=1 and motor_ready=1; every valid beat is discarded, not stamped, does not change last-grant.
REQ-027 drop_count SHALL add the number of beats discarded per cycle (0, 1 or 2), saturating at all-ones; never decremented.
REQ-028 enable falling during HOLD SHALL NOT cancel the held event; it completes normally, discard begins on return to IDLE.
REQ-029 enable rising SHALL take effect in the same cycle for IDLE arbitration (combinational use).

Reset
REQ-030 While reset=0, SHALL force state IDLE, out_valid=0, out_tag=00, out_data=0, out_timestamp=0, timestamp counter=0, drop_count=0, last-grant=motor, regardless of clk.
REQ-031 Reset asserted during HOLD SHALL drop the held event without handshake; head_ready/motor_ready SHALL be 0 while reset=0.
REQ-032 After reset release, first accept SHALL be possible on the first rising edge.

Verification
REQ-033 Both valid every cycle, out_ready=1, enable=1 -> tags alternate 01,10,01,10, out_valid one cycle in two, head first.
REQ-034 motor_data=0xFFFFFFF6 alone accepted at timestamp 5 -> out_tag=10, out_data[31:0]=0xFFFFFFF6, upper bits 0, out_timestamp=5, held stable while out_ready=0 for 10 cycles.
REQ-035 enable=0, both valid for 3 cycles -> both readies high, drop_count=6, out_valid stays 0; with DROP_WIDTH=2, drop_count saturates at 3.
REQ-036 Head event in HOLD, out_ready=0, enable driven 0 -> event still delivered on out_ready=1, subsequent beats discarded.
REQ-037 reset=0 mid-HOLD (async, between edges) -> out_valid=0 immediately, timestamp=0, drop_count=0; after release head-only valid accepted on first edge.
REQ-038 Timestamp near wrap (TIMESTAMP_WIDTH=4, accept at count 15 then 0) -> out_timestamp 15 then 0.

Source files
------------

// File: rtl/print_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : print_event_arbiter
// Description : Round-robin merge of thermal-head lines and motor step events
//               into one timestamped output, with drop counting when disabled.
// Revision    : 1.0 - initial release
// ============================================================================
module print_event_arbiter #(
    parameter int TIMESTAMP_WIDTH = 32,
    parameter int DROP_WIDTH      = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       head_valid,
    output logic                       head_ready,
    input  logic [511:0]               head_data,
    input  logic                       motor_valid,
    output logic                       motor_ready,
    input  logic [31:0]                motor_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [1:0]                 out_tag,
    output logic [511:0]               out_data,
    output logic [TIMESTAMP_WIDTH-1:0] out_timestamp,
    output logic [DROP_WIDTH-1:0]      drop_count
);

    localparam logic [1:0] c_TAG_NONE  = 2'b00;
    localparam logic [1:0] c_TAG_HEAD  = 2'b01;
    localparam logic [1:0] c_TAG_MOTOR = 2'b10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t                     r_state;
    state_t                     w_state_next;
    logic                       r_last_motor;
    logic [TIMESTAMP_WIDTH-1:0] r_ts;
    logic [DROP_WIDTH-1:0]      r_drop;
    logic [1:0]                 r_out_tag;
    logic [511:0]               r_out_data;
    logic [TIMESTAMP_WIDTH-1:0] r_out_ts;

    logic                       w_idle;
    logic                       w_grant_head;
    logic                       w_grant_motor;
    logic                       w_accept_head;
    logic                       w_accept_motor;
    logic [1:0]                 w_discard_cnt;
    logic [DROP_WIDTH:0]        w_drop_sum;
    logic [DROP_WIDTH-1:0]      w_drop_next;

    // Readies are gated by reset so nothing handshakes while held in reset.
    assign w_idle         = (r_state == ST_IDLE) && reset;
    assign w_grant_head   = head_valid && (!motor_valid || r_last_motor);
    assign w_grant_motor  = motor_valid && !w_grant_head;
    assign w_accept_head  = w_idle && enable && w_grant_head;
    assign w_accept_motor = w_idle && enable && w_grant_motor;

    assign head_ready  = w_idle && (enable ? w_grant_head  : 1'b1);
    assign motor_ready = w_idle && (enable ? w_grant_motor : 1'b1);

    assign w_discard_cnt = (w_idle && !enable)
                         ? ({1'b0, head_valid} + {1'b0, motor_valid})
                         : 2'd0;
    assign w_drop_sum    = {1'b0, r_drop} + (DROP_WIDTH+1)'(w_discard_cnt);
    assign w_drop_next   = w_drop_sum[DROP_WIDTH] ? {DROP_WIDTH{1'b1}}
                                                  : w_drop_sum[DROP_WIDTH-1:0];

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept_head || w_accept_motor) begin
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ts         <= '0;
            r_drop       <= '0;
            r_last_motor <= 1'b1;
            r_out_tag    <= c_TAG_NONE;
            r_out_data   <= '0;
            r_out_ts     <= '0;
        end else begin
            r_ts   <= r_ts + TIMESTAMP_WIDTH'(1);
            r_drop <= w_drop_next;
            if (w_accept_head) begin
                r_out_tag    <= c_TAG_HEAD;
                r_out_data   <= head_data;
                r_out_ts     <= r_ts;
                r_last_motor <= 1'b0;
            end else if (w_accept_motor) begin
                r_out_tag    <= c_TAG_MOTOR;
                r_out_data   <= {480'd0, motor_data};
                r_out_ts     <= r_ts;
                r_last_motor <= 1'b1;
            end else if ((r_state == ST_HOLD) && out_ready) begin
                // Output bus returns to all-zero between events.
                r_out_tag  <= c_TAG_NONE;
                r_out_data <= '0;
                r_out_ts   <= '0;
            end
        end
    end

    assign out_valid     = (r_state == ST_HOLD);
    assign out_tag       = r_out_tag;
    assign out_data      = r_out_data;
    assign out_timestamp = r_out_ts;
    assign drop_count    = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_print_event_arbiter.sv
`default_nettype none
// Directed bench for print_event_arbiter: a default-width instance and a
// narrow one (4-bit timestamp, 2-bit drop counter) share the same stimulus.
module tb_print_event_arbiter;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         enable = 1'b1;
    logic         head_valid = 1'b0;
    logic [511:0] head_data = '0;
    logic         motor_valid = 1'b0;
    logic [31:0]  motor_data = '0;
    logic         out_ready = 1'b1;

    logic         head_ready, motor_ready, out_valid;
    logic [1:0]   out_tag;
    logic [511:0] out_data;
    logic [31:0]  out_timestamp;
    logic [15:0]  drop_count;

    logic         s_head_ready, s_motor_ready, s_out_valid;
    logic [1:0]   s_out_tag;
    logic [511:0] s_out_data;
    logic [3:0]   s_out_timestamp;
    logic [1:0]   s_drop_count;

    typedef struct {
        logic [1:0]   tag;
        logic [511:0] data;
        logic [31:0]  ts;
    } ev_t;

    ev_t sb[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;

    always #5 clk = ~clk;

    // Reference cycle count: value the DUT counter holds during the current cycle.
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    print_event_arbiter dut (
        .clk(clk), .reset(reset), .enable(enable),
        .head_valid(head_valid), .head_ready(head_ready), .head_data(head_data),
        .motor_valid(motor_valid), .motor_ready(motor_ready), .motor_data(motor_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
        .out_data(out_data), .out_timestamp(out_timestamp), .drop_count(drop_count)
    );

    print_event_arbiter #(.TIMESTAMP_WIDTH(4), .DROP_WIDTH(2)) dut_small (
        .clk(clk), .reset(reset), .enable(enable),
        .head_valid(head_valid), .head_ready(s_head_ready), .head_data(head_data),
        .motor_valid(motor_valid), .motor_ready(s_motor_ready), .motor_data(motor_data),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_tag(s_out_tag),
        .out_data(s_out_data), .out_timestamp(s_out_timestamp), .drop_count(s_drop_count)
    );

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs just after the falling edge, check away from
    // the rising edge, optionally push an expected event, then wait a cycle.
    // push: 0 none, 1 head accepted this cycle, 2 motor accepted this cycle.
    task automatic step(input logic hv, input logic mv, input logic en, input logic ordy,
                        input logic exp_hr, input logic exp_mr, input logic exp_ov,
                        input int push);
        ev_t e;
        head_valid  = hv;
        motor_valid = mv;
        enable      = en;
        out_ready   = ordy;
        #1;
        chk("head_ready", 512'(head_ready), 512'(exp_hr));
        chk("motor_ready", 512'(motor_ready), 512'(exp_mr));
        chk("out_valid", 512'(out_valid), 512'(exp_ov));
        chk("small_out_valid", 512'(s_out_valid), 512'(exp_ov));
        if (out_valid) begin
            if (sb.size() == 0) begin
                chk("sb_nonempty", 512'(0), 512'(1));
            end else begin
                chk("out_tag", 512'(out_tag), 512'(sb[0].tag));
                chk("out_data", out_data, sb[0].data);
                chk("out_timestamp", 512'(out_timestamp), 512'(sb[0].ts));
                chk("small_out_timestamp", 512'(s_out_timestamp), 512'(sb[0].ts[3:0]));
                if (ordy) void'(sb.pop_front());
            end
        end else begin
            chk("idle_out_tag", 512'(out_tag), 512'(0));
            chk("idle_out_data", out_data, 512'(0));
        end
        if (push == 1) begin
            e.tag = 2'b01; e.data = head_data; e.ts = 32'(cyc);
            sb.push_back(e);
        end else if (push == 2) begin
            e.tag = 2'b10; e.data = {480'd0, motor_data}; e.ts = 32'(cyc);
            sb.push_back(e);
        end
        @(negedge clk);
    endtask

    initial begin
        // Reset: everything cleared and readies low even with valid inputs.
        head_valid = 1'b1;
        motor_valid = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 512'(out_valid), 512'(0));
        chk("rst_out_tag", 512'(out_tag), 512'(0));
        chk("rst_out_data", out_data, 512'(0));
        chk("rst_out_ts", 512'(out_timestamp), 512'(0));
        chk("rst_drop", 512'(drop_count), 512'(0));
        chk("rst_head_ready", 512'(head_ready), 512'(0));
        chk("rst_motor_ready", 512'(motor_ready), 512'(0));
        @(negedge clk);
        reset = 1'b1;

        // Both requesters always valid: head first, then alternation.
        head_data  = {16{32'hA5A5_0001}};
        motor_data = 32'h0000_1234;
        step(1, 1, 1, 1, 1, 0, 0, 1);
        step(1, 1, 1, 1, 0, 0, 1, 0);
        step(1, 1, 1, 1, 0, 1, 0, 2);
        step(1, 1, 1, 1, 0, 0, 1, 0);
        head_data  = {16{32'h5A5A_F00D}};
        step(1, 1, 1, 1, 1, 0, 0, 1);
        step(1, 1, 1, 1, 0, 0, 1, 0);
        step(0, 0, 1, 1, 0, 0, 0, 0);

        // Negative motor count alone, held with out_ready low for 10 cycles.
        motor_data = 32'hFFFF_FFF6;
        step(0, 1, 1, 1, 0, 1, 0, 2);
        for (int i = 0; i < 10; i++) step(1, 1, 1, 0, 0, 0, 1, 0);
        step(0, 0, 1, 1, 0, 0, 1, 0);

        // Head held while enable drops; it still completes, then discard.
        head_data = {8{64'hDEAD_BEEF_0BAD_F00D}};
        step(1, 0, 1, 1, 1, 0, 0, 1);
        step(1, 1, 0, 0, 0, 0, 1, 0);
        step(1, 1, 0, 0, 0, 0, 1, 0);
        step(1, 1, 0, 1, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            chk("drop_count", 512'(drop_count), 512'(2 * i));
            chk("small_drop_count", 512'(s_drop_count), 512'((i == 0) ? 0 : (i == 1) ? 2 : 3));
            step(1, 1, 0, 1, 1, 1, 0, 0);
        end
        chk("drop_count_6", 512'(drop_count), 512'(6));
        chk("small_drop_sat", 512'(s_drop_count), 512'(3));
        // Enable rising is used for arbitration in the same cycle.
        step(1, 0, 1, 1, 1, 0, 0, 1);
        step(0, 0, 1, 1, 0, 0, 1, 0);
        chk("drop_count_kept", 512'(drop_count), 512'(6));

        // Timestamp wrap on the narrow instance: accept at 15, later at 0.
        for (int i = 0; i < 40 && (cyc % 16) != 15; i++) step(0, 0, 1, 1, 0, 0, 0, 0);
        head_data = {16{32'h0F0F_0F0F}};
        step(1, 0, 1, 1, 1, 0, 0, 1);
        step(0, 0, 1, 1, 0, 0, 1, 0);
        for (int i = 0; i < 40 && (cyc % 16) != 0; i++) step(0, 0, 1, 1, 0, 0, 0, 0);
        motor_data = 32'h8000_0000;
        step(0, 1, 1, 1, 0, 1, 0, 2);
        step(0, 0, 1, 1, 0, 0, 1, 0);

        // Asynchronous reset in the middle of a held event.
        head_data = {16{32'h1357_9BDF}};
        step(1, 0, 1, 1, 1, 0, 0, 1);
        head_valid = 1'b1;
        out_ready  = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("arst_out_valid", 512'(out_valid), 512'(0));
        chk("arst_out_tag", 512'(out_tag), 512'(0));
        chk("arst_out_data", out_data, 512'(0));
        chk("arst_out_ts", 512'(out_timestamp), 512'(0));
        chk("arst_drop", 512'(drop_count), 512'(0));
        chk("arst_head_ready", 512'(head_ready), 512'(0));
        sb.delete();
        @(negedge clk);
        reset = 1'b1;
        head_data = {16{32'h2468_ACE0}};
        step(1, 0, 1, 1, 1, 0, 0, 1);
        step(0, 0, 1, 1, 0, 0, 1, 0);
        chk("sb_drained", 512'(sb.size()), 512'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
